// File: rtl/mem_stage_controller_if.sv
// Bundle of the memory stage's upstream, BRAM-addresser and writeback signals.
// The controller uses the slave view; whatever drives the stage uses the master view.
interface mem_stage_controller_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_access_code;
    logic [31:0] in_address;
    logic [31:0] in_store_value;
    logic [31:0] in_alu_result;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_load_unsigned;
    logic [4:0]  addr_access_code;
    logic [31:0] addr_address;
    logic [31:0] addr_store_data;
    logic [31:0] addr_read_data;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        wb_fault;

    modport master (
        output in_valid, in_access_code, in_address, in_store_value, in_alu_result,
               in_rd, in_reg_write, in_load_unsigned, addr_read_data, wb_ready,
        input  in_ready, addr_access_code, addr_address, addr_store_data,
               wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault
    );

    modport slave (
        input  in_valid, in_access_code, in_address, in_store_value, in_alu_result,
               in_rd, in_reg_write, in_load_unsigned, addr_read_data, wb_ready,
        output in_ready, addr_access_code, addr_address, addr_store_data,
               wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault
    );
endinterface

// File: rtl/mem_stage_controller.sv
// Memory-stage sequencer: issues one access to the BRAM addresser, waits out the
// read latency, extends load data and hands a registered payload to writeback.
module mem_stage_controller #(
    parameter int READ_LATENCY    = 1,
    parameter int ADDR_LIMIT_BITS = 18
) (
    input  logic CLOCK_50,
    input  logic reset,
    mem_stage_controller_if.slave bus
);

    localparam logic [4:0] C_LB = 5'b10000;
    localparam logic [4:0] C_LH = 5'b11000;
    localparam logic [4:0] C_LW = 5'b11110;
    localparam logic [4:0] C_SB = 5'b10001;
    localparam logic [4:0] C_SH = 5'b11001;
    localparam logic [4:0] C_SW = 5'b11111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [4:0]  r_code;
    logic        r_reg_write;
    logic        r_unsigned;
    logic [4:0]  r_addr_code;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_reg_write;
    logic        r_wb_fault;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_is_mem;
    logic        w_fault;
    logic [31:0] w_high_bits;

    function automatic logic is_legal(input logic [4:0] code);
        return (code == 5'b00000) || (code == C_LB) || (code == C_LH) || (code == C_LW) ||
               (code == C_SB) || (code == C_SH) || (code == C_SW);
    endfunction

    // Addresser is big-endian: the addressed byte lives in bits [31:24].
    function automatic logic [31:0] justify_store(input logic [4:0] code, input logic [31:0] v);
        case (code)
            C_SB:    return {v[7:0], 24'h0};
            C_SH:    return {v[15:0], 16'h0};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [4:0] code, input logic uns,
                                                input logic [31:0] d);
        case (code)
            C_LB:    return uns ? {24'h0, d[31:24]} : {{24{d[31]}}, d[31:24]};
            C_LH:    return uns ? {16'h0, d[31:16]} : {{16{d[31]}}, d[31:16]};
            default: return d;
        endcase
    endfunction

    assign w_in_ready  = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.wb_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_is_mem    = (bus.in_access_code != 5'b00000);
    assign w_high_bits = bus.in_address >> ADDR_LIMIT_BITS;
    assign w_fault     = !is_legal(bus.in_access_code) || (w_is_mem && (w_high_bits != '0));

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 3'd0;
            r_code         <= 5'd0;
            r_reg_write    <= 1'b0;
            r_unsigned     <= 1'b0;
            r_addr_code    <= 5'd0;
            r_addr         <= 32'd0;
            r_store_data   <= 32'd0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_data      <= 32'd0;
            r_wb_reg_write <= 1'b0;
            r_wb_fault     <= 1'b0;
        end else if (w_accept) begin
            r_code      <= bus.in_access_code;
            r_reg_write <= bus.in_reg_write;
            r_unsigned  <= bus.in_load_unsigned;
            r_wb_rd     <= bus.in_rd;
            r_wb_fault  <= w_fault;
            if (w_fault) begin
                r_addr_code    <= 5'd0;
                r_wb_valid     <= 1'b1;
                r_wb_data      <= 32'd0;
                r_wb_reg_write <= 1'b0;
                r_state        <= S_OUT;
            end else if (!w_is_mem) begin
                r_addr_code    <= 5'd0;
                r_wb_valid     <= 1'b1;
                r_wb_data      <= bus.in_alu_result;
                r_wb_reg_write <= bus.in_reg_write;
                r_state        <= S_OUT;
            end else begin
                r_addr_code  <= bus.in_access_code;
                r_addr       <= bus.in_address;
                r_store_data <= justify_store(bus.in_access_code, bus.in_store_value);
                r_cnt        <= 3'(READ_LATENCY);
                r_wb_valid   <= 1'b0;
                r_state      <= S_WAIT;
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    // The write strobe is visible for the first WAIT cycle only.
                    r_addr_code[0] <= 1'b0;
                    if (r_code[0]) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= 32'd0;
                        r_wb_reg_write <= 1'b0;
                        r_state        <= S_OUT;
                    end else if (r_cnt == 3'd0) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= extend_load(r_code, r_unsigned, bus.addr_read_data);
                        r_wb_reg_write <= r_reg_write;
                        r_state        <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_OUT: begin
                    if (bus.wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.addr_access_code = r_addr_code;
    assign bus.addr_address     = r_addr;
    assign bus.addr_store_data  = r_store_data;
    assign bus.wb_valid         = r_wb_valid;
    assign bus.wb_rd            = r_wb_rd;
    assign bus.wb_data          = r_wb_data;
    assign bus.wb_reg_write     = r_wb_reg_write;
    assign bus.wb_fault         = r_wb_fault;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Bench for mem_stage_controller: two instances (read latency 1 and 3) see the
// same stimulus and are compared against a byte-count based reference model.
module tb_mem_stage_controller;

    localparam int ALB = 18;
    localparam logic [4:0] LB = 5'b10000, LH = 5'b11000, LW = 5'b11110;
    localparam logic [4:0] SB = 5'b10001, SH = 5'b11001, SW = 5'b11111;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    mem_stage_controller_if if1();
    mem_stage_controller_if if3();

    mem_stage_controller #(.READ_LATENCY(1), .ADDR_LIMIT_BITS(ALB)) dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(if1));
    mem_stage_controller #(.READ_LATENCY(3), .ADDR_LIMIT_BITS(ALB)) dut3 (
        .CLOCK_50(CLOCK_50), .reset(reset), .bus(if3));

    assign if3.in_valid         = if1.in_valid;
    assign if3.in_access_code   = if1.in_access_code;
    assign if3.in_address       = if1.in_address;
    assign if3.in_store_value   = if1.in_store_value;
    assign if3.in_alu_result    = if1.in_alu_result;
    assign if3.in_rd            = if1.in_rd;
    assign if3.in_reg_write     = if1.in_reg_write;
    assign if3.in_load_unsigned = if1.in_load_unsigned;
    assign if3.addr_read_data   = if1.addr_read_data;
    assign if3.wb_ready         = if1.wb_ready;

    logic        s_ready[2], s_valid[2], s_fault[2], s_regw[2];
    logic [31:0] s_data[2], s_addr[2], s_sdata[2];
    logic [4:0]  s_rd[2], s_code[2];

    assign s_ready[0] = if1.in_ready;         assign s_ready[1] = if3.in_ready;
    assign s_valid[0] = if1.wb_valid;         assign s_valid[1] = if3.wb_valid;
    assign s_fault[0] = if1.wb_fault;         assign s_fault[1] = if3.wb_fault;
    assign s_regw[0]  = if1.wb_reg_write;     assign s_regw[1]  = if3.wb_reg_write;
    assign s_data[0]  = if1.wb_data;          assign s_data[1]  = if3.wb_data;
    assign s_addr[0]  = if1.addr_address;     assign s_addr[1]  = if3.addr_address;
    assign s_sdata[0] = if1.addr_store_data;  assign s_sdata[1] = if3.addr_store_data;
    assign s_rd[0]    = if1.wb_rd;            assign s_rd[1]    = if3.wb_rd;
    assign s_code[0]  = if1.addr_access_code; assign s_code[1]  = if3.addr_access_code;

    typedef struct {
        bit          fault;
        bit          mem;
        bit          store;
        logic [31:0] data;
        bit          regw;
        logic [31:0] sdata;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] c);
        return c inside {5'b00000, LB, LH, LW, SB, SH, SW};
    endfunction

    // Reference: width in bytes = number of enables; data justified by shifting.
    function automatic exp_t model(input logic [4:0] code, input logic [31:0] addr,
                                   input logic [31:0] st, input logic [31:0] alu,
                                   input logic regw, input logic uns,
                                   input logic [31:0] rdata);
        exp_t   e;
        int     nb;
        longint v;
        nb      = $countones(code[4:1]);
        e.mem   = (code != 5'b00000);
        e.store = code[0];
        e.fault = !is_legal(code) || (e.mem && (longint'(addr) >= (longint'(1) << ALB)));
        e.data  = 32'd0;
        e.regw  = 1'b0;
        e.sdata = 32'd0;
        if (e.fault) begin
            e.data = 32'd0;
        end else if (!e.mem) begin
            e.data = alu;
            e.regw = regw;
        end else if (e.store) begin
            e.sdata = 32'(longint'(st) << (8 * (4 - nb)));
        end else begin
            v = longint'(rdata) >> (8 * (4 - nb));
            if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            e.data = 32'(v);
            e.regw = regw;
        end
        return e;
    endfunction

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_in_ready"}, 32'(s_ready[d]), 32'd1);
            chk({tag, "_wb_valid"}, 32'(s_valid[d]), 32'd0);
            chk({tag, "_wb_fault"}, 32'(s_fault[d]), 32'd0);
            chk({tag, "_wb_regw"},  32'(s_regw[d]),  32'd0);
            chk({tag, "_wb_rd"},    32'(s_rd[d]),    32'd0);
            chk({tag, "_wb_data"},  s_data[d],       32'd0);
            chk({tag, "_acode"},    32'(s_code[d]),  32'd0);
            chk({tag, "_aaddr"},    s_addr[d],       32'd0);
            chk({tag, "_asdata"},   s_sdata[d],      32'd0);
        end
    endtask

    task automatic drive(input logic [4:0] code, input logic [31:0] addr, input logic [31:0] st,
                         input logic [31:0] alu, input logic [4:0] rd, input logic regw,
                         input logic uns);
        if1.in_access_code   = code;
        if1.in_address       = addr;
        if1.in_store_value   = st;
        if1.in_alu_result    = alu;
        if1.in_rd            = rd;
        if1.in_reg_write     = regw;
        if1.in_load_unsigned = uns;
    endtask

    task automatic txn(input logic [4:0] code, input logic [31:0] addr, input logic [31:0] st,
                       input logic [31:0] alu, input logic [4:0] rd, input logic regw,
                       input logic uns, input logic [31:0] rdata);
        exp_t        e;
        int          lat[2], nwr[2], explat;
        logic [31:0] dat[2], a0[2], sd0[2];
        logic [4:0]  c0[2], rdo[2];
        logic        flt[2], rw[2];
        e = model(code, addr, st, alu, regw, uns, rdata);
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1; nwr[d] = 0; dat[d] = '0; a0[d] = '0; sd0[d] = '0;
            c0[d] = '0; rdo[d] = '0; flt[d] = 1'b0; rw[d] = 1'b0;
        end
        @(negedge CLOCK_50);
        for (int d = 0; d < 2; d++) chk("idle_in_ready", 32'(s_ready[d]), 32'd1);
        drive(code, addr, st, alu, rd, regw, uns);
        if1.addr_read_data = rdata;
        if1.wb_ready       = 1'b1;
        if1.in_valid       = 1'b1;
        @(posedge CLOCK_50);
        #1 if1.in_valid = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge CLOCK_50);
            for (int d = 0; d < 2; d++) begin
                if (n == 0) begin
                    c0[d] = s_code[d]; a0[d] = s_addr[d]; sd0[d] = s_sdata[d];
                end
                if (s_code[d][0]) nwr[d]++;
                if (s_valid[d] && lat[d] < 0) begin
                    lat[d] = n; dat[d] = s_data[d]; flt[d] = s_fault[d];
                    rw[d] = s_regw[d]; rdo[d] = s_rd[d];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            explat = (e.fault || !e.mem) ? 0 : (e.store ? 1 : ((d == 0) ? 1 : 3) + 1);
            chk($sformatf("latency_rl%0d", d * 2 + 1), 32'(lat[d]), 32'(explat));
            chk("wb_fault", 32'(flt[d]), 32'(e.fault));
            chk("wb_reg_write", 32'(rw[d]), 32'(e.regw));
            if (!e.fault) begin
                chk("wb_data", dat[d], e.data);
                chk("wb_rd", 32'(rdo[d]), 32'(rd));
            end
            chk("addr_code_first", 32'(c0[d]), (e.fault || !e.mem) ? 32'd0 : 32'(code));
            chk("write_strobes", 32'(nwr[d]), (!e.fault && e.store) ? 32'd1 : 32'd0);
            if (!e.fault && e.mem) chk("addr_address", a0[d], addr);
            if (!e.fault && e.store) chk("addr_store_data", sd0[d], e.sdata);
        end
    endtask

    initial begin
        logic [4:0]  rc;
        logic [31:0] ra;
        reset = 1'b1;
        if1.in_valid = 1'b0;
        if1.wb_ready = 1'b0;
        if1.addr_read_data = '0;
        drive(5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge CLOCK_50);
        #1 check_zero("reset");
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check_zero("post_reset");

        txn(5'b00000, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 1'b0, 32'h0);
        txn(SB, 32'h103, 32'hAABB_CCDD, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0);
        txn(LB, 32'h103, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 32'hDD11_2233);
        txn(LB, 32'h103, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 32'hDD11_2233);
        txn(LH, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 32'h8001_7F00);
        txn(LW, 32'h100, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 32'h8001_7F00);
        txn(SH, 32'h3_FFFE, 32'h1234_ABCD, 32'h0, 5'd2, 1'b1, 1'b0, 32'h0);
        txn(SW, 32'h20, 32'hDEAD_BEEF, 32'h0, 5'd2, 1'b1, 1'b0, 32'h0);
        txn(LW, 32'h0004_0000, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h5555_5555);
        txn(5'b10100, 32'h10, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 32'h0);
        txn(SW, 32'h8000_0000, 32'h1, 32'h0, 5'd1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: rc = 5'b00000;
                1: rc = LB;
                2: rc = LH;
                3: rc = LW;
                4: rc = SB;
                5: rc = SH;
                6: rc = SW;
                default: begin
                    rc = 5'($urandom);
                    while (is_legal(rc)) rc = 5'($urandom);
                end
            endcase
            ra = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'($urandom_range(0, (1 << ALB) - 1));
            txn(rc, ra, 32'($urandom), 32'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                32'($urandom));
        end

        // Backpressure: payload A held in OUT while B waits on the bus.
        @(negedge CLOCK_50);
        if1.wb_ready = 1'b0;
        drive(5'b00000, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd7, 1'b1, 1'b0);
        if1.in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 drive(5'b00000, 32'h0, 32'h0, 32'h0BAD_BEEF, 5'd9, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge CLOCK_50);
            for (int d = 0; d < 2; d++) begin
                chk("hold_wb_valid", 32'(s_valid[d]), 32'd1);
                chk("hold_wb_data", s_data[d], 32'hCAFE_F00D);
                chk("hold_wb_rd", 32'(s_rd[d]), 32'd7);
                chk("hold_in_ready", 32'(s_ready[d]), 32'd0);
            end
        end
        if1.wb_ready = 1'b1;
        #1 for (int d = 0; d < 2; d++) chk("release_in_ready", 32'(s_ready[d]), 32'd1);
        @(posedge CLOCK_50);
        #1 if1.in_valid = 1'b0;
        @(negedge CLOCK_50);
        for (int d = 0; d < 2; d++) begin
            chk("next_wb_valid", 32'(s_valid[d]), 32'd1);
            chk("next_wb_data", s_data[d], 32'h0BAD_BEEF);
            chk("next_wb_rd", 32'(s_rd[d]), 32'd9);
            chk("next_wb_regw", 32'(s_regw[d]), 32'd0);
        end
        @(negedge CLOCK_50);
        for (int d = 0; d < 2; d++) chk("drain_wb_valid", 32'(s_valid[d]), 32'd0);

        // Reset between clock edges while a store is in its first WAIT cycle.
        drive(SW, 32'h200, 32'h1122_3344, 32'h0, 5'd3, 1'b0, 1'b0);
        if1.in_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 if1.in_valid = 1'b0;
        @(negedge CLOCK_50);
        for (int d = 0; d < 2; d++) chk("wait_acode", 32'(s_code[d]), 32'(SW));
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        @(negedge CLOCK_50);
        reset = 1'b0;
        txn(5'b00000, 32'h0, 32'h0, 32'h0000_00A5, 5'd31, 1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
- Sequencing stage between the execute/memory pipeline register and the memory/writeback pipeline register.
- Accepts one instruction per handshake and drives the BRAM addresser's inputs (memory_access_code, memory_address, data_to_store).
- Waits out the synchronous BRAM read latency, then sign- or zero-extends the returned load data.
- Presents a registered writeback payload under a valid/ready handshake, stalling upstream while busy.

Parameters:
- READ_LATENCY, 1, clock edges from the BRAM sampling the address to read data being stable at addresser output (1..7).
- ADDR_LIMIT_BITS, 18, number of low address bits backed by BRAM; any higher set bit is a fault.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_access_code  in  5  [0]=store, [4:1]=byte enables; 0 = non-memory op.
- in_address  in  32  effective byte address.
- in_store_value  in  32  rs2 value, right-justified.
- in_alu_result  in  32  passthrough result for non-memory ops.
- in_rd  in  5  destination register.
- in_reg_write  in  1  instruction writes rd.
- in_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- addr_access_code  out  5  to addresser.
- addr_address  out  32  to addresser.
- addr_store_data  out  32  to addresser, left-justified.
- addr_read_data  in  32  writeback_register_data from addresser.
- wb_valid  out  1  payload valid.
- wb_ready  in  1  downstream accepts.
- wb_rd  out  5  destination register.
- wb_data  out  32  result value.
- wb_reg_write  out  1  write enable for writeback.
- wb_fault  out  1  illegal code or out-of-range address.

Behaviour:
- Legal codes: LB=10000, LH=11000, LW=11110, SB=10001, SH=11001, SW=11111, NOP=00000.
- Byte at the effective address maps to bits [31:24] of addresser data (big-endian).
- Reset: state IDLE, in_ready=1, wb_valid=0, wb_fault=0, wb_reg_write=0, wb_rd=0, wb_data=0, addr_access_code=0, addr_address=0, addr_store_data=0.
- Outputs hold reset values until the first accept.
- in_ready = (state==IDLE) | (state==OUT & wb_ready).
- Accept = in_valid & in_ready. On accept, latch all inputs.
- Fault check on accept: illegal code, or memory op with in_address[31:ADDR_LIMIT_BITS] != 0.
- On fault: addr_access_code=0; go to OUT with wb_fault=1, wb_reg_write=0.
- Non-memory (code 0): go to OUT next edge with wb_data=in_alu_result and wb_reg_write=in_reg_write.
- Memory op: go to WAIT and load cnt=READ_LATENCY.
  - addr_address = latched address throughout WAIT.
  - addr_access_code = latched code in the first WAIT cycle only; afterwards bit0 is forced to 0, so exactly one write per store.
- Store data left-justification:
  - SB: store[7:0] to [31:24], rest 0.
  - SH: store[15:0] to [31:16], rest 0.
  - SW: unchanged.
- Store: leaves WAIT after 1 cycle and goes to OUT with wb_reg_write=0, wb_data=0.
- Load in WAIT: if cnt==0, capture and go to OUT; else cnt decrements.
  - wb_valid rises READ_LATENCY+1 edges after the accept edge.
- Load extension:
  - LB: bits [31:24], sign/zero extended to 32.
  - LH: bits [31:16], extended to 32.
  - LW: all 32 bits.
  - wb_reg_write = latched in_reg_write.
- OUT: wb_valid=1 and the payload is stable while wb_ready=0.
  - If wb_ready & in_valid: accept the new instruction on the same edge, with no bubble.
  - If wb_ready only: go to IDLE and drop wb_valid.
- Only one instruction is in flight; in_ready=0 throughout WAIT.
- Reset asserted mid-WAIT or mid-OUT: immediately return to reset values; a partially issued store is not retried.

Test Plan:
- Reset, then ALU op (code 0, alu=0x1234_5678, rd=5) with wb_ready=1 -> wb_valid one edge after accept, wb_data=0x12345678, wb_reg_write=1, wb_rd=5.
- SB addr=0x103, store=0xAABBCCDD -> addr_store_data=0xDD000000; bit0 set exactly one cycle; wb_reg_write=0.
- Then LB addr=0x103, unsigned=0, with addresser returning 0xDD...... -> wb_data=0xFFFFFFDD after READ_LATENCY+1 edges.
  - With unsigned=1 -> wb_data=0x000000DD.
- LH with read data 0x80017F00, signed -> 0xFFFF8001; LW -> 0x80017F00. Repeat with READ_LATENCY=3 and check wb_valid timing.
- Hold wb_ready=0 for 4 cycles in OUT with in_valid=1 -> payload stable and in_ready=0; release -> next instruction accepted on the same edge.
- LW addr=0x0004_0000 -> wb_fault=1, addr_access_code stays 0, no BRAM write. Code 10100 -> fault.
  - Assert reset mid-WAIT -> all outputs return to 0 asynchronously.
